// File: rtl/music_pkg.sv
// Shared definitions for the music datapath: song-entry layout, note codes and
// the sequencer state encoding.
package music_pkg;

  localparam int unsigned EntryW  = 16;
  localparam int unsigned EndBit  = 15;
  localparam int unsigned OctLsb  = 13;
  localparam int unsigned OctW    = 2;
  localparam int unsigned NoteLsb = 9;
  localparam int unsigned NoteW   = 4;
  localparam int unsigned DurLsb  = 0;
  localparam int unsigned DurW    = 9;

  localparam logic [NoteW-1:0] NoteRest = 4'd0;
  localparam logic [NoteW-1:0] NoteMin  = 4'd1;
  localparam logic [NoteW-1:0] NoteMax  = 4'd12;

  typedef logic [DurW-1:0] dur_t;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLoad,
    StPlay,
    StGap,
    StDone
  } state_e;

  // Codes 0 and 13-15 are rests; only 1-12 drive the tone generator.
  function automatic logic note_is_tone(input logic [NoteW-1:0] note);
    return (note >= NoteMin) && (note <= NoteMax);
  endfunction

endpackage

// File: rtl/ms_ticker.sv
// Millisecond strobe generator: one-cycle ms_tick every max(ticks_per_milli,1)
// cycles, restartable with clear.
module ms_ticker (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic [15:0] ticks_per_milli,
  output logic        ms_tick
);

  logic [15:0] cnt_q, cnt_d;
  logic [15:0] limit;

  // The >= compare lets a mid-count drop of ticks_per_milli fire immediately
  // instead of waiting for a 16-bit wrap.
  always_comb begin
    limit   = (ticks_per_milli == 16'd0) ? 16'd0 : ticks_per_milli - 16'd1;
    ms_tick = !clear && (cnt_q >= limit);
    cnt_d   = (clear || ms_tick) ? 16'd0 : cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/note_sequencer.sv
// Walks the song ROM and turns each entry into timed note/octave/enable
// commands for the tone generator, plus LED, busy and done status.
module note_sequencer
  import music_pkg::*;
#(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned LOOP   = 1,
  parameter int unsigned GAP_MS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       ticks_per_milli,
  input  logic              start,
  input  logic              stop,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic [3:0]        note,
  output logic [1:0]        octave,
  output logic              tone_en,
  output logic [7:0]        led,
  output logic              busy,
  output logic              done
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  dur_t              ms_q, ms_d;
  logic [NoteW-1:0]  lat_note_q, lat_note_d;
  logic [OctW-1:0]   lat_oct_q, lat_oct_d;

  logic [3:0] note_q, note_d;
  logic [1:0] octave_q, octave_d;
  logic       tone_en_q, tone_en_d;
  logic [7:0] led_q, led_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic             ms_tick;
  logic             tick_clear;
  logic             e_end;
  logic [OctW-1:0]  e_oct;
  logic [NoteW-1:0] e_note;
  dur_t             e_dur;
  logic             play_d;

  // Outside the timed states the ticker is held at zero so PLAY/GAP start fresh.
  assign tick_clear = !((state_q == StPlay) || (state_q == StGap));

  ms_ticker u_ms_ticker (
    .clk             (clk),
    .rst             (rst),
    .clear           (tick_clear),
    .ticks_per_milli (ticks_per_milli),
    .ms_tick         (ms_tick)
  );

  assign e_end  = rom_data[EndBit];
  assign e_oct  = rom_data[OctLsb +: OctW];
  assign e_note = rom_data[NoteLsb +: NoteW];
  assign e_dur  = rom_data[DurLsb +: DurW];

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    ms_d       = ms_q;
    lat_note_d = lat_note_q;
    lat_oct_d  = lat_oct_q;

    if (stop) begin
      state_d = StIdle;
      ptr_d   = '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_d = StFetch;
            ptr_d   = '0;
          end
        end
        StFetch: state_d = StLoad;
        StLoad: begin
          if (e_end) begin
            // An end marker at address 0 is an empty song: never loop on it.
            if ((LOOP != 0) && (ptr_q != '0)) begin
              ptr_d   = '0;
              state_d = StFetch;
            end else begin
              state_d = StDone;
            end
          end else begin
            lat_note_d = e_note;
            lat_oct_d  = e_oct;
            ms_d       = (e_dur == '0) ? dur_t'(1) : e_dur;
            state_d    = StPlay;
          end
        end
        StPlay: begin
          if (ms_tick) begin
            if (ms_q <= dur_t'(1)) begin
              if (GAP_MS != 0) begin
                ms_d    = dur_t'(GAP_MS);
                state_d = StGap;
              end else begin
                ptr_d   = ptr_q + ADDR_W'(1);
                state_d = StFetch;
              end
            end else begin
              ms_d = ms_q - dur_t'(1);
            end
          end
        end
        StGap: begin
          if (ms_tick) begin
            if (ms_q <= dur_t'(1)) begin
              ptr_d   = ptr_q + ADDR_W'(1);
              state_d = StFetch;
            end else begin
              ms_d = ms_q - dur_t'(1);
            end
          end
        end
        default: begin
          state_d = StIdle;
          ptr_d   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they are registered yet line up
  // with the state they describe.
  always_comb begin
    play_d    = (state_d == StPlay);
    tone_en_d = play_d && note_is_tone(lat_note_d);
    note_d    = play_d ? lat_note_d : NoteRest;
    octave_d  = play_d ? lat_oct_d : 2'd0;
    led_d     = tone_en_d ? (8'd1 << lat_note_d[2:0]) : 8'd0;
    busy_d    = (state_d == StFetch) || (state_d == StLoad) ||
                (state_d == StPlay) || (state_d == StGap);
    done_d    = (state_d == StDone) && (state_q != StDone);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      ms_q       <= '0;
      lat_note_q <= '0;
      lat_oct_q  <= '0;
      note_q     <= '0;
      octave_q   <= '0;
      tone_en_q  <= 1'b0;
      led_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      ms_q       <= ms_d;
      lat_note_q <= lat_note_d;
      lat_oct_q  <= lat_oct_d;
      note_q     <= note_d;
      octave_q   <= octave_d;
      tone_en_q  <= tone_en_d;
      led_q      <= led_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign rom_addr = ptr_q;
  assign note     = note_q;
  assign octave   = octave_q;
  assign tone_en  = tone_en_q;
  assign led      = led_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
